ifft64_out_reorder: RTL
=======================

Name: ifft64_out_reorder

Overview:
- Output reorder buffer placed directly downstream of ifft64_radix2_top.
- Accepts the two-lane, bit-reversed 64-point IFFT output stream, 32 beats per frame, qualified by the start_check valid.
- Re-emits each frame in natural bin order on two lanes: lane0 carries bins 0..31, lane1 carries bins 32..63.
- Double-buffered (ping-pong), so back-to-back frames stream with no stall and no backpressure.

Parameters:
- DW, 16, width of each real/imag component (two's complement).
- HALF_LOG2, 5, log2 of beats per frame (32 beats, 64 points); not intended to be changed.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- arst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input beat valid (driven from ifft start_check).
- in0_re  in  DW  lane0 real (ifft_out0_re).
- in0_im  in  DW  lane0 imag.
- in1_re  in  DW  lane1 real (ifft_out1_re).
- in1_im  in  DW  lane1 imag.
- sync_clr  in  1  synchronous frame resync; discards the partial input frame.
- out_valid  out  1  output beat valid.
- out_first  out  1  high on output beat 0 of a frame.
- out_last  out  1  high on output beat 31 of a frame.
- out_idx  out  5  output beat number n.
- out0_re  out  DW  bin n, real.
- out0_im  out  DW  bin n, imag.
- out1_re  out  DW  bin n+32, real.
- out1_im  out  DW  bin n+32, imag.

Behaviour:
- Input order is fixed. On the c-th valid beat of a frame (c = 0..31):
  - lane0 carries bin bitrev6(2c) = bitrev5(c).
  - lane1 carries bin bitrev6(2c+1) = 32 + bitrev5(c).
- Storage: two banks (ping/pong). Each bank has a lower memory and an upper memory, each 32 x 2*DW.
  - lane0 writes the lower memory at address bitrev5(c).
  - lane1 writes the upper memory at address bitrev5(c).
- Write counter wcnt (5 bit):
  - Increments only on in_valid.
  - Gaps in in_valid are allowed; the frame simply stretches.
  - When wcnt wraps 31->0, the written bank is marked full and the write bank toggles.
- Reader, two states:
  - IDLE: when a full bank exists, go to READ.
  - READ: rcnt = 0..31, one beat per cycle, unconditional. At rcnt = 31 the bank is marked empty and the reader returns to IDLE, or stays in READ if the other bank is full (gapless).
- Read data is registered. Beat n drives:
  - out0 = lower[n], out1 = upper[n]
  - out_idx = n
  - out_first = (n == 0), out_last = (n == 31)
- Latency: if the last input beat of a frame is sampled at edge T, output beat 0 appears after edge T+2 and beat 31 after edge T+33.
- Throughput:
  - Reading a frame takes exactly 32 cycles. Writing the next frame takes at least 32 cycles.
  - Overflow is therefore impossible.
  - A write into a bank that is still full is a design error; flag it with a simulation assertion only (no port).
- sync_clr:
  - Forces wcnt = 0. The partial frame is dropped and the write bank is unchanged.
  - If in_valid is high in the same cycle, that beat is written as c = 0.
  - Does not affect a read in progress.
- Reset (arst = 1):
  - Immediately clears wcnt, rcnt, bank select and both full flags, and returns the reader to IDLE.
  - All outputs go to 0.
  - Memory contents are don't-care.
  - A reset mid-frame or mid-read discards everything; output resumes only after a complete new 32-beat frame.
- When out_valid = 0, the data outputs hold 0.

Decomposition:
- Package ifft64_pkg:
  - DW, HALF_LOG2, N_BEATS = 32.
  - bitrev5 function.
  - Packed complex type {re, im}, 2*DW.
- Sub-module reorder_bank_ram:
  - 32 x 2*DW, simple dual port: one write, one registered read.
  - Instantiated four times (ping/pong x lower/upper).
- Top contains the write counter, full flags, reader FSM and output registers.

Test Plan:
- Single frame: drive bin k as re = k, im = -k in ifft order with continuous in_valid, last beat at edge T.
  - Required: beats 0..31 after edges T+2..T+33.
  - Beat n has out0 = (n, -n) and out1 = (n+32, -(n+32)).
  - out_first only at n = 0; out_last only at n = 31.
- Back-to-back: 3 frames with per-frame offsets 0 / 100 / 200, continuous valid.
  - Required: 96 consecutive out_valid cycles with no gap.
  - Frame 2 beat 5 gives out0 = (105, -105) and out1 = (137, -137).
- Gapped input: in_valid toggles 1/0 every cycle over one frame.
  - Required: output identical to the single-frame case.
  - Output starts 2 cycles after the 32nd valid beat.
- sync_clr mid-frame: 10 beats, then sync_clr together with in_valid on a fresh frame's beat 0, then 31 more beats.
  - Required: exactly one output frame, containing the fresh data only.
- Reset mid-read: assert arst at output beat 12.
  - Required: all outputs 0 immediately; no output until a complete new frame is written, which then emerges correctly at T+2.
- Post-reset idle: after reset, 31 valid beats only.
  - Required: out_valid stays 0 indefinitely.

Source files
------------

// File: rtl/ifft64_pkg.sv
// ifft64_pkg: shared constants, types and helpers for the 64-point IFFT output reorder buffer.
//   DW        - width of one real/imag component (two's complement)
//   HALF_LOG2 - log2 of beats per frame (32 beats carry 64 points on two lanes)
//   N_BEATS   - beats per frame
//   cplx_t    - packed complex sample {re, im}, 2*DW bits
//   bitrev5   - 5-bit bit reversal, maps input beat number to natural bin address
package ifft64_pkg;

  localparam int unsigned DW        = 16;
  localparam int unsigned HALF_LOG2 = 5;
  localparam int unsigned N_BEATS   = 1 << HALF_LOG2;

  typedef logic [HALF_LOG2-1:0] beat_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  function automatic beat_t bitrev5(input beat_t x);
    beat_t r;
    for (int i = 0; i < int'(HALF_LOG2); i++) begin
      r[i] = x[int'(HALF_LOG2) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft64_out_reorder_if.sv
// ifft64_out_reorder_if: stream bundle around the IFFT output reorder buffer.
//   in_valid, in0_*/in1_*  - bit-reversed two-lane input beat from the IFFT
//   sync_clr               - synchronous resync, drops the partial input frame
//   out_valid/first/last   - natural-order output beat qualifiers
//   out_idx                - output beat number n
//   out0_*/out1_*          - bin n and bin n+32
// Modports: master drives the input stream and observes the output, slave is the buffer.
interface ifft64_out_reorder_if;
  import ifft64_pkg::*;

  logic                 in_valid;
  logic [DW-1:0]        in0_re;
  logic [DW-1:0]        in0_im;
  logic [DW-1:0]        in1_re;
  logic [DW-1:0]        in1_im;
  logic                 sync_clr;

  logic                 out_valid;
  logic                 out_first;
  logic                 out_last;
  logic [HALF_LOG2-1:0] out_idx;
  logic [DW-1:0]        out0_re;
  logic [DW-1:0]        out0_im;
  logic [DW-1:0]        out1_re;
  logic [DW-1:0]        out1_im;

  modport master (
    output in_valid, in0_re, in0_im, in1_re, in1_im, sync_clr,
    input  out_valid, out_first, out_last, out_idx, out0_re, out0_im, out1_re, out1_im
  );

  modport slave (
    input  in_valid, in0_re, in0_im, in1_re, in1_im, sync_clr,
    output out_valid, out_first, out_last, out_idx, out0_re, out0_im, out1_re, out1_im
  );

endinterface

// File: rtl/reorder_bank_ram.sv
// reorder_bank_ram: simple dual-port RAM, one write port and one registered read port.
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address, sampled every cycle
//   rdata_o - read data, valid the cycle after raddr_i
// No reset: contents and read register are don't-care until written.
module reorder_bank_ram #(
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ifft64_out_reorder.sv
// ifft64_out_reorder: ping-pong reorder buffer turning the bit-reversed two-lane IFFT output
// into natural bin order (lane0 = bins 0..31, lane1 = bins 32..63), 32 beats per frame.
//   clk  - clock
//   arst - asynchronous reset, active high; clears counters, flags, reader and outputs
//   bus  - slave side of ifft64_out_reorder_if (input stream, sync_clr, output stream)
// Each bank holds a lower (lane0) and upper (lane1) RAM written at bitrev5(beat); the reader
// streams a full bank out linearly, chaining straight into the other bank when it is full.
module ifft64_out_reorder
  import ifft64_pkg::*;
(
  input logic                 clk,
  input logic                 arst,
  ifft64_out_reorder_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRead} rd_state_e;

  localparam beat_t LastBeat = beat_t'(N_BEATS - 1);

  // Write side
  beat_t     wcnt_q, wcnt_d;
  beat_t     wr_beat, wr_addr;
  logic      wr_wrap;
  logic      wbank_q, wbank_d;
  logic [1:0] full_q, full_d;

  // Read side
  rd_state_e state_q, state_d;
  beat_t     rcnt_q, rcnt_d;
  logic      rbank_q, rbank_d;
  logic      rd_active, rd_done;

  // Output registers
  logic      out_valid_q, out_valid_d;
  beat_t     out_idx_q, out_idx_d;
  logic      obank_q;

  cplx_t     lo_rdata [2];
  cplx_t     up_rdata [2];
  cplx_t     rd0, rd1;

  // sync_clr restarts the frame; a beat arriving with it is beat 0 of the new frame.
  always_comb begin
    wr_beat = bus.sync_clr ? '0 : wcnt_q;
    wr_addr = bitrev5(wr_beat);
    wr_wrap = bus.in_valid && (wr_beat == LastBeat);
    wcnt_d  = wcnt_q;
    if (bus.in_valid) begin
      wcnt_d = wr_beat + 1'b1;
    end else if (bus.sync_clr) begin
      wcnt_d = '0;
    end
    wbank_d = wbank_q ^ wr_wrap;
  end

  always_comb begin
    full_d = full_q;
    if (rd_done) begin
      full_d[rbank_q] = 1'b0;
    end
    if (wr_wrap) begin
      full_d[wbank_q] = 1'b1;
    end
  end

  // Reader FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (full_q[rbank_q]) state_d = StRead;
      StRead: if (rd_done && !full_q[!rbank_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reader FSM: outputs / datapath controls
  always_comb begin
    rd_active   = (state_q == StRead);
    rd_done     = rd_active && (rcnt_q == LastBeat);
    rcnt_d      = rd_active ? rcnt_q + 1'b1 : '0;
    rbank_d     = rbank_q ^ rd_done;
    out_valid_d = rd_active;
    out_idx_d   = rd_active ? rcnt_q : '0;
  end

  // Reader FSM: state register plus the rest of the control state
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= StIdle;
      rcnt_q      <= '0;
      rbank_q     <= 1'b0;
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      obank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      rbank_q     <= rbank_d;
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      // Tracks which bank the RAM read registers captured this cycle.
      obank_q     <= rbank_q;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic we;
    assign we = bus.in_valid && (wbank_q == 1'(b));

    reorder_bank_ram #(
      .Width (2 * DW),
      .AddrW (HALF_LOG2)
    ) u_lower (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (wr_addr),
      .wdata_i ({bus.in0_re, bus.in0_im}),
      .raddr_i (rcnt_q),
      .rdata_o (lo_rdata[b])
    );

    reorder_bank_ram #(
      .Width (2 * DW),
      .AddrW (HALF_LOG2)
    ) u_upper (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (wr_addr),
      .wdata_i ({bus.in1_re, bus.in1_im}),
      .raddr_i (rcnt_q),
      .rdata_o (up_rdata[b])
    );
  end

  // RAM read registers are not reset, so data is forced to zero outside a valid beat.
  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (out_valid_q) begin
      rd0 = obank_q ? lo_rdata[1] : lo_rdata[0];
      rd1 = obank_q ? up_rdata[1] : up_rdata[0];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_valid_q && (out_idx_q == '0);
  assign bus.out_last  = out_valid_q && (out_idx_q == LastBeat);
  assign bus.out_idx   = out_idx_q;
  assign bus.out0_re   = rd0.re;
  assign bus.out0_im   = rd0.im;
  assign bus.out1_re   = rd1.re;
  assign bus.out1_im   = rd1.im;

  // A bank may only be rewritten once its read has finished (release on the same edge is ok).
  a_no_overwrite : assert property (@(posedge clk) disable iff (arst)
    !(bus.in_valid && full_q[wbank_q] && !(rd_done && (rbank_q == wbank_q))))
    else $error("write into a bank that is still full");

endmodule
